// File: rtl/mlp_sequencer_if.sv
// mlp_sequencer_if: control handshake and SRAM/MAC strobe bundle
// between the MLP sequencer (slave) and its requester/datapath (master).
interface mlp_sequencer_if #(
  parameter int N_IMG = 10
);
  logic             start;
  logic [3:0]       img_sel;
  logic             stall;
  logic             busy;
  logic             done;
  logic             err;
  logic [N_IMG-1:0] img_en;
  logic [9:0]       address_in;
  logic [17:0]      address_1;
  logic [11:0]      address_2;
  logic [7:0]       hid_addr;
  logic             hid_we;
  logic             out_we;
  logic [3:0]       out_idx;
  logic             layer_sel;
  logic             mac_en;
  logic             mac_clr;

  modport master (
    output start, img_sel, stall,
    input  busy, done, err, img_en,
    input  address_in, address_1, address_2,
    input  hid_addr, hid_we, out_we, out_idx,
    input  layer_sel, mac_en, mac_clr
  );

  modport slave (
    input  start, img_sel, stall,
    output busy, done, err, img_en,
    output address_in, address_1, address_2,
    output hid_addr, hid_we, out_we, out_idx,
    output layer_sel, mac_en, mac_clr
  );
endinterface

// File: rtl/mlp_sequencer.sv
// mlp_sequencer: control FSM for the two-layer MLP datapath.
// Walks image/weight SRAMs per neuron, strobes MAC and writeback.
module mlp_sequencer #(
  parameter int N_IN  = 784,
  parameter int N_HID = 256,
  parameter int N_OUT = 10,
  parameter int N_IMG = 10
) (
  input logic            clk,
  input logic            reset,
  mlp_sequencer_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [9:0] K1_LAST = 10'(N_IN - 1);
  localparam logic [9:0] K2_LAST = 10'(N_HID - 1);
  localparam logic [7:0] J1_LAST = 8'(N_HID - 1);
  localparam logic [7:0] J2_LAST = 8'(N_OUT - 1);
  localparam logic [3:0] IMG_LIM = 4'(N_IMG);
  localparam logic [N_IMG-1:0] IMG_ONE = N_IMG'(1);

  logic [2:0]       state_q, state_d;
  logic             l_q, l_d;
  logic [7:0]       j_q, j_d;
  logic [9:0]       k_q, k_d;
  logic [3:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [N_IMG-1:0] img_en_q, img_en_d;
  logic [9:0]       ain_q, ain_d;
  logic [17:0]      a1_q, a1_d;
  logic [11:0]      a2_q, a2_d;
  logic [7:0]       hid_q, hid_d;
  logic             hwe_q, hwe_d;
  logic             owe_q, owe_d;
  logic [3:0]       oidx_q, oidx_d;
  logic             men_q, men_d;
  logic             mclr_q, mclr_d;
  logic             k_last, j_last, consume;

  always_comb begin
    k_last  = k_q == (l_q ? K2_LAST : K1_LAST);
    j_last  = j_q == (l_q ? J2_LAST : J1_LAST);
    consume = (state_q == S_ISSUE) && !bus.stall;
    state_d  = state_q;
    l_d      = l_q;
    j_d      = j_q;
    k_d      = k_q;
    sel_d    = sel_q;
    ain_d    = ain_q;
    a1_d     = a1_q;
    a2_d     = a2_q;
    hid_d    = hid_q;
    oidx_d   = oidx_q;
    err_d    = 1'b0;
    hwe_d    = 1'b0;
    owe_d    = 1'b0;
    img_en_d = '0;
    // read data returns one cycle after the address is consumed
    men_d    = consume;
    mclr_d   = consume && (k_q == '0);
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (bus.start) begin
          if (bus.img_sel < IMG_LIM) begin
            state_d = S_ISSUE;
            sel_d   = bus.img_sel;
            l_d     = 1'b0;
            j_d     = '0;
            k_d     = '0;
            a1_d    = '0;
            a2_d    = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      state_q == S_ISSUE: begin
        if (consume) begin
          if (k_last) begin
            state_d = S_DRAIN;
          end else begin
            k_d = k_q + 10'd1;
            if (l_q) a2_d = a2_q + 12'd1;
            else     a1_d = a1_q + 18'd1;
          end
        end
      end
      state_q == S_DRAIN: state_d = S_WB;
      state_q == S_WB: begin
        state_d = S_ISSUE;
        k_d     = '0;
        j_d     = j_q + 8'd1;
        if (!j_last) begin
          if (l_q) a2_d = a2_q + 12'd1;
          else     a1_d = a1_q + 18'd1;
        end else if (!l_q) begin
          l_d = 1'b1;
          j_d = '0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ISSUE) begin
      if (!l_d) begin
        img_en_d = IMG_ONE << sel_d;
        ain_d    = k_d;
      end else begin
        hid_d = k_d[7:0];
      end
    end
    if (state_d == S_WB) begin
      if (!l_q) begin
        hwe_d = 1'b1;
        hid_d = j_q;
      end else begin
        owe_d  = 1'b1;
        oidx_d = j_q[3:0];
      end
    end
    busy_d = state_d inside {S_ISSUE, S_DRAIN, S_WB};
    done_d = state_d == S_DONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      l_q      <= 1'b0;
      j_q      <= '0;
      k_q      <= '0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      img_en_q <= '0;
      ain_q    <= '0;
      a1_q     <= '0;
      a2_q     <= '0;
      hid_q    <= '0;
      hwe_q    <= 1'b0;
      owe_q    <= 1'b0;
      oidx_q   <= '0;
      men_q    <= 1'b0;
      mclr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      l_q      <= l_d;
      j_q      <= j_d;
      k_q      <= k_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      img_en_q <= img_en_d;
      ain_q    <= ain_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      hid_q    <= hid_d;
      hwe_q    <= hwe_d;
      owe_q    <= owe_d;
      oidx_q   <= oidx_d;
      men_q    <= men_d;
      mclr_q   <= mclr_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.img_en     = img_en_q;
  assign bus.address_in = ain_q;
  assign bus.address_1  = a1_q;
  assign bus.address_2  = a2_q;
  assign bus.hid_addr   = hid_q;
  assign bus.hid_we     = hwe_q;
  assign bus.out_we     = owe_q;
  assign bus.out_idx    = oidx_q;
  assign bus.layer_sel  = l_q;
  assign bus.mac_en     = men_q;
  assign bus.mac_clr    = mclr_q;
endmodule

// File: tb/tb_mlp_sequencer.sv
// tb_mlp_sequencer: small instance checked every cycle against a
// schedule-queue model; mid-size instance checked on totals.
module tb_mlp_sequencer;
  localparam int SI = 4;
  localparam int SH = 3;
  localparam int SO = 2;
  localparam int MI = 100;
  localparam int MH = 50;
  localparam int MO = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mlp_sequencer_if #(.N_IMG(10)) bs ();
  mlp_sequencer_if #(.N_IMG(10)) bm ();

  mlp_sequencer #(
    .N_IN(SI), .N_HID(SH), .N_OUT(SO), .N_IMG(10)
  ) u_small (
    .clk(clk), .reset(reset), .bus(bs)
  );

  mlp_sequencer #(
    .N_IN(MI), .N_HID(MH), .N_OUT(MO), .N_IMG(10)
  ) u_mid (
    .clk(clk), .reset(reset), .bus(bm)
  );

  typedef struct {
    int kind;
    int l;
    int j;
    int k;
  } item_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0 = 0;
  int tm0 = 0;

  item_t sched[$];
  int m_sel = 0;
  int n_stall_iss = 0;
  logic e_busy = 0, e_done = 0, e_err = 0;
  logic e_hwe = 0, e_owe = 0, e_lsel = 0;
  logic e_men = 0, e_mclr = 0;
  logic [9:0] e_img = '0, e_ain = '0;
  logic [17:0] e_a1 = '0;
  logic [11:0] e_a2 = '0;
  logic [7:0] e_hid = '0;
  logic [3:0] e_oidx = '0;

  int n_men = 0, n_mclr = 0, n_err = 0, n_busy = 0;
  int done_rel = -1;
  logic [9:0] img_or = '0;
  int hwe_c[$], hwe_a[$], owe_c[$], owe_a[$];
  int nm_men = 0, nm_hwe = 0, nm_owe = 0, mdone = -1;
  int ma1 = 0, ma2 = 0;

  logic [69:0] act_s, exp_s, act_m;
  assign act_s = {bs.busy, bs.done, bs.err, bs.img_en,
                  bs.address_in, bs.address_1, bs.address_2,
                  bs.hid_addr, bs.hid_we, bs.out_we, bs.out_idx,
                  bs.layer_sel, bs.mac_en, bs.mac_clr};
  assign exp_s = {e_busy, e_done, e_err, e_img,
                  e_ain, e_a1, e_a2,
                  e_hid, e_hwe, e_owe, e_oidx,
                  e_lsel, e_men, e_mclr};
  assign act_m = {bm.busy, bm.done, bm.err, bm.img_en,
                  bm.address_in, bm.address_1, bm.address_2,
                  bm.hid_addr, bm.hid_we, bm.out_we, bm.out_idx,
                  bm.layer_sel, bm.mac_en, bm.mac_clr};

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole run as a flat list of work items: 0 issue, 1 drain, 2 wb, 3 done
  task automatic build_sched();
    sched.delete();
    for (int j = 0; j < SH; j++) begin
      for (int k = 0; k < SI; k++) sched.push_back('{0, 0, j, k});
      sched.push_back('{1, 0, j, 0});
      sched.push_back('{2, 0, j, 0});
    end
    for (int j = 0; j < SO; j++) begin
      for (int k = 0; k < SH; k++) sched.push_back('{0, 1, j, k});
      sched.push_back('{1, 1, j, 0});
      sched.push_back('{2, 1, j, 0});
    end
    sched.push_back('{3, 1, 0, 0});
  endtask

  task automatic model_step();
    item_t it;
    if (reset) begin
      sched.delete();
      {e_busy, e_done, e_err, e_hwe, e_owe} = '0;
      {e_lsel, e_men, e_mclr} = '0;
      e_img = '0; e_ain = '0; e_a1 = '0;
      e_a2 = '0; e_hid = '0; e_oidx = '0;
      return;
    end
    {e_done, e_err, e_hwe, e_owe, e_men, e_mclr} = '0;
    e_img = '0;
    if (sched.size() > 0) begin
      it = sched[0];
      if (it.kind == 0 && bs.stall) begin
        n_stall_iss++;
      end else begin
        if (it.kind == 0) begin
          e_men = 1'b1;
          e_mclr = (it.k == 0);
        end
        void'(sched.pop_front());
      end
    end else if (bs.start) begin
      if (int'(bs.img_sel) < 10) begin
        build_sched();
        m_sel = int'(bs.img_sel);
        e_a1 = '0;
        e_a2 = '0;
      end else begin
        e_err = 1'b1;
      end
    end
    e_busy = 1'b0;
    if (sched.size() > 0) begin
      it = sched[0];
      e_lsel = it.l[0];
      e_busy = (it.kind != 3);
      e_done = (it.kind == 3);
      if (it.kind == 0 && it.l == 0) begin
        e_img = 10'(1 << m_sel);
        e_ain = 10'(it.k);
        e_a1 = 18'(it.j * SI + it.k);
      end else if (it.kind == 0) begin
        e_hid = 8'(it.k);
        e_a2 = 12'(it.j * SH + it.k);
      end else if (it.kind == 2 && it.l == 0) begin
        e_hwe = 1'b1;
        e_hid = 8'(it.j);
      end else if (it.kind == 2) begin
        e_owe = 1'b1;
        e_oidx = 4'(it.j);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk($sformatf("outs@%0d", cyc - t0), act_s, exp_s);
    if (bs.mac_en) n_men++;
    if (bs.mac_clr) n_mclr++;
    if (bs.err) n_err++;
    if (bs.busy) n_busy++;
    img_or |= bs.img_en;
    if (bs.hid_we) begin
      hwe_c.push_back(cyc - t0);
      hwe_a.push_back(int'(bs.hid_addr));
    end
    if (bs.out_we) begin
      owe_c.push_back(cyc - t0);
      owe_a.push_back(int'(bs.out_idx));
    end
    if (bs.done && done_rel < 0) done_rel = cyc - t0;
    if (bm.mac_en) nm_men++;
    if (bm.hid_we) nm_hwe++;
    if (bm.out_we) nm_owe++;
    if (bm.done && mdone < 0) begin
      mdone = cyc - tm0;
      ma1 = int'(bm.address_1);
      ma2 = int'(bm.address_2);
    end
  end

  task automatic clr_obs();
    n_men = 0; n_mclr = 0; n_err = 0; n_busy = 0;
    done_rel = -1; n_stall_iss = 0; img_or = '0;
    hwe_c.delete(); hwe_a.delete();
    owe_c.delete(); owe_a.delete();
  endtask

  task automatic run_small(input int sel, input int st_at,
                           input int st_len, input bit rnd,
                           input int rs_at);
    clr_obs();
    @(posedge clk); #1;
    t0 = cyc;
    bs.start = 1'b1;
    bs.img_sel = 4'(sel);
    for (int c = 1; c < 400 && done_rel < 0; c++) begin
      @(posedge clk); #1;
      bs.start = (c == rs_at);
      bs.stall = (c >= st_at && c < st_at + st_len) ||
                 (rnd && $urandom_range(3) == 0);
    end
    bs.start = 1'b0;
    bs.stall = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bs.start = 0; bs.img_sel = 0; bs.stall = 0;
    bm.start = 0; bm.img_sel = 0; bm.stall = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s", act_s, 0);
    chk("rst_m", act_m, 0);
    reset = 1'b0;

    run_small(2, 0, 0, 1'b0, 0);
    chk("done", done_rel, 29);
    chk("men", n_men, 18);
    chk("mclr", n_mclr, 5);
    chk("img_or", img_or, 10'b100);
    chk("hwe_n", hwe_c.size(), 3);
    for (int i = 0; i < 3 && i < hwe_c.size(); i++) begin
      chk("hwe_cyc", hwe_c[i], 6 + 6 * i);
      chk("hwe_adr", hwe_a[i], i);
    end
    chk("owe_n", owe_c.size(), 2);
    for (int i = 0; i < 2 && i < owe_c.size(); i++) begin
      chk("owe_cyc", owe_c[i], 23 + 5 * i);
      chk("owe_idx", owe_a[i], i);
    end

    run_small(5, 2, 3, 1'b0, 0);
    chk("done_st", done_rel, 32);
    chk("men_st", n_men, 18);

    clr_obs();
    @(posedge clk); #1;
    t0 = cyc;
    bs.start = 1'b1;
    bs.img_sel = 4'(10 + $urandom_range(5));
    @(posedge clk); #1;
    bs.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("err_n", n_err, 1);
    chk("err_busy", n_busy, 0);

    run_small(7, 0, 0, 1'b0, 10);
    chk("done_rs", done_rel, 29);

    for (int r = 0; r < 3; r++) begin
      run_small(int'($urandom_range(9)), 0, 0, 1'b1, 0);
      chk("done_rnd", done_rel, 29 + n_stall_iss);
      chk("men_rnd", n_men, 18);
    end

    clr_obs();
    @(posedge clk); #1;
    t0 = cyc;
    bs.start = 1'b1;
    bs.img_sel = 4'd1;
    @(posedge clk); #1;
    bs.start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    chk("busy_l2", bs.layer_sel & bs.busy, 1);
    reset = 1'b1;
    #1;
    chk("arst_s", act_s, 0);
    chk("arst_m", act_m, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_small(3, 0, 0, 1'b0, 0);
    chk("done_rst", done_rel, 29);

    mdone = -1; nm_men = 0; nm_hwe = 0; nm_owe = 0;
    @(posedge clk); #1;
    tm0 = cyc;
    bm.start = 1'b1;
    bm.img_sel = 4'($urandom_range(9));
    @(posedge clk); #1;
    bm.start = 1'b0;
    for (int c = 0; c < 7000 && mdone < 0; c++) @(posedge clk);
    #1;
    chk("m_done", mdone, 1 + MH * (MI + 2) + MO * (MH + 2));
    chk("m_a1", ma1, MH * MI - 1);
    chk("m_a2", ma2, MO * MH - 1);
    chk("m_men", nm_men, MH * MI + MO * MH);
    chk("m_hwe", nm_hwe, MH);
    chk("m_owe", nm_owe, MO);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
